lab2_proc_decode_imm_sched: RTL and testbench
=============================================

# lab2_proc_decode_imm_sched

Decode-stage immediate scheduler for the five-stage pipeline. It accepts fetched instructions over a val/rdy interface and classifies each opcode into an immediate format for the downstream immediate generator. Decoded entries are held in a 2-entry elastic buffer and released to the X stage under val/rdy, with branch-squash support and a saturating illegal-instruction counter.

## Interface
Parameters:
- `p_depth`, 2: buffer entries; only 2 is supported.
- `p_cnt_nbits`, 8: width of the illegal-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-low.
- `in_val`  in  1  fetched instruction valid.
- `in_rdy`  out  1  scheduler can accept.
- `in_inst`  in  32  instruction word.
- `squash`  in  1  flush all buffered entries (taken branch/jump from X).
- `out_val`  out  1  head entry valid.
- `out_rdy`  in  1  X stage accepts head.
- `out_inst`  out  32  head instruction.
- `out_imm_type`  out  3  immediate format: 0=I, 1=S, 2=B, 3=U, 4=J.
- `out_imm_use`  out  1  instruction consumes an immediate.
- `out_illegal`  out  1  opcode unsupported.
- `illegal_cnt`  out  `p_cnt_nbits`  count of illegal entries dequeued.

## Operation
- Decode uses `inst[6:0]`:
  - 0000011, 0010011, 1100111: I, use=1.
  - 0100011: S, use=1.
  - 1100011: B, use=1.
  - 0110111, 0010111: U, use=1.
  - 1101111: J, use=1.
  - 0110011: type=0, use=0.
  - Anything else: type=0, use=0, illegal=1.
- Decode happens at enqueue. The buffer stores {inst, imm_type, imm_use, illegal}.
- Buffer state:
  - `count` ∈ {0,1,2}.
  - Head pointer and tail pointer are 1 bit each and wrap 1→0.
- Handshakes:
  - Enqueue fire = `in_val & in_rdy & ~squash`.
  - Dequeue fire = `out_val & out_rdy & ~squash`.
  - `in_rdy` = `reset` high & `count` != 2. It is combinational on state only, never on `in_val`.
  - `out_val` = `count` != 0.
  - No bypass from input to output: an empty buffer never presents the input in the same cycle.
- Simultaneous enqueue and dequeue at `count`=1: `count` stays 1, head advances, tail advances.
- Full (`count`=2): `in_rdy`=0. A dequeue in this cycle does not allow enqueue in the same cycle.
- Squash: next `count`=0 and pointers reset to 0. A same-cycle `in_val` is dropped, not stored. A same-cycle `out_rdy` is not a dequeue. Squash takes priority over every other event.
- `illegal_cnt`: increments by 1 on each dequeue fire whose head `illegal`=1. It saturates at 2^`p_cnt_nbits`−1. It is not cleared by squash. Squashed illegal entries are not counted.
- When `out_val`=0, `out_inst`, `out_imm_type`, `out_imm_use` and `out_illegal` drive 0.

## Timing
- Reset (`reset`=0 at an edge): `count`=0, pointers=0, `illegal_cnt`=0.
- Outputs while reset is asserted: `out_val`=0, `in_rdy`=0, data outputs 0.
- Reset mid-operation discards all entries. Reset dominates squash.
- Latency: an instruction enqueued at edge N is visible on `out_*` with `out_val`=1 in cycle N+1.
- Throughput: 1 instruction/cycle when `out_rdy` is held high.
- `out_*` are driven from buffer registers through a head mux only. No combinational path from `in_*` to `out_*`.
- No combinational path from `out_rdy` to `in_rdy`.

## Structure
- Shared package `lab2_proc_imm_pkg` holds:
  - immediate-type constants `IMM_I`..`IMM_J` (3 bits);
  - opcode constants `OPC_LOAD`, `OPC_OPIMM`, `OPC_JALR`, `OPC_STORE`, `OPC_BRANCH`, `OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_OP`.
  - The immediate generator's `imm_type` select uses these same constants.
- One sub-module, `lab2_proc_imm_type_decode`: combinational, `inst[6:0]` → {imm_type, imm_use, illegal}. It is instantiated once on the enqueue path.
- The buffer storage and control stay in the top module.

## Test plan
- Reset then single op: release reset, enqueue 0x00500093 (addi) at cycle 1.
  - Cycle 2: `out_val`=1, type=0, use=1, illegal=0.
  - Dequeue: `count`=0.
- Format sweep: enqueue sw 0x00112023, beq 0x00208463, lui 0x123450B7, jal 0x008000EF, add 0x002081B3 with `out_rdy`=1.
  - Types out in order: 1, 2, 3, 4, 0 (use=0).
  - One instruction per cycle, no bubbles.
- Full/backpressure: `out_rdy`=0, enqueue 3 instructions.
  - Third is held: `in_rdy`=0 after 2 enqueues.
  - Raise `out_rdy`: order is preserved and pointers wrap correctly.
- Squash with simultaneous events: `count`=2, assert `squash` with `in_val`=1 and `out_rdy`=1.
  - Next cycle: `out_val`=0, `count`=0.
  - `illegal_cnt` unchanged; no entry consumed.
- Illegal counting: enqueue 0xFFFFFFFF (opcode 1111111) 300 times with `out_rdy`=1.
  - `out_illegal`=1 each time.
  - `illegal_cnt` saturates at 255.
  - An illegal entry squashed before dequeue is not counted.
- Reset mid-stream: assert `reset`=0 with `count`=2.
  - Next cycle: `out_val`=0, `in_rdy`=0, `illegal_cnt`=0.
  - After release: `in_rdy`=1.

Source files
------------

// File: rtl/lab2_proc_imm_pkg.sv
// Shared immediate-format and opcode constants for the decode scheduler
// and the downstream immediate generator.
package lab2_proc_imm_pkg;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // One buffered decode entry, captured at enqueue time.
   typedef struct packed {
      logic [31:0] inst;
      logic [2:0]  imm_type;
      logic        imm_use;
      logic        illegal;
   } dec_entry_t;

endpackage

// File: rtl/lab2_proc_imm_type_decode.sv
// Combinational opcode classifier: maps inst[6:0] to the immediate
// format, whether an immediate is consumed, and whether it is illegal.
module lab2_proc_imm_type_decode
   import lab2_proc_imm_pkg::*;
(
   input  logic [6:0] opcode,
   output logic [2:0] imm_type,
   output logic       imm_use,
   output logic       illegal
);

   // Opcode to immediate-format lookup; unknown opcodes flag illegal.
   always_comb begin
      imm_type = IMM_I;
      imm_use  = 1'b0;
      illegal  = 1'b0;
      case (opcode)
         OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
            imm_type = IMM_I;
            imm_use  = 1'b1;
         end
         OPC_STORE: begin
            imm_type = IMM_S;
            imm_use  = 1'b1;
         end
         OPC_BRANCH: begin
            imm_type = IMM_B;
            imm_use  = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            imm_type = IMM_U;
            imm_use  = 1'b1;
         end
         OPC_JAL: begin
            imm_type = IMM_J;
            imm_use  = 1'b1;
         end
         OPC_OP: begin
            imm_type = IMM_I;
            imm_use  = 1'b0;
         end
         default: begin
            imm_type = IMM_I;
            imm_use  = 1'b0;
            illegal  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/lab2_proc_decode_imm_sched.sv
// Decode-stage immediate scheduler: classifies fetched instructions and
// holds them in a 2-entry elastic buffer released to X under val/rdy.
module lab2_proc_decode_imm_sched
   import lab2_proc_imm_pkg::*;
#(
   parameter int p_depth     = 2,
   parameter int p_cnt_nbits = 8
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_val,
   output logic                   in_rdy,
   input  logic [31:0]            in_inst,
   input  logic                   squash,
   output logic                   out_val,
   input  logic                   out_rdy,
   output logic [31:0]            out_inst,
   output logic [2:0]             out_imm_type,
   output logic                   out_imm_use,
   output logic                   out_illegal,
   output logic [p_cnt_nbits-1:0] illegal_cnt
);

   localparam logic [p_cnt_nbits-1:0] CNT_MAX = {p_cnt_nbits{1'b1}};

   function automatic logic [p_cnt_nbits-1:0] sat_inc(input logic [p_cnt_nbits-1:0] v);
      if (v == CNT_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + {{(p_cnt_nbits-1){1'b0}}, 1'b1};
      end
   endfunction

   logic [1:0]             count_q, count_d;
   logic                   head_q, head_d;
   logic                   tail_q, tail_d;
   logic [p_cnt_nbits-1:0] illegal_cnt_q, illegal_cnt_d;
   dec_entry_t             ent_q [p_depth];
   dec_entry_t             ent_d [p_depth];

   logic       enq_fire;
   logic       deq_fire;
   dec_entry_t new_ent;
   dec_entry_t head_ent;

   lab2_proc_imm_type_decode u_decode (
      .opcode   (in_inst[6:0]),
      .imm_type (new_ent.imm_type),
      .imm_use  (new_ent.imm_use),
      .illegal  (new_ent.illegal)
   );
   assign new_ent.inst = in_inst;

   // Handshake terms depend on state and reset only, so out_rdy never reaches in_rdy.
   always_comb begin
      in_rdy   = reset & (count_q != 2'd2);
      out_val  = reset & (count_q != 2'd0);
      enq_fire = in_val & in_rdy & ~squash;
      deq_fire = out_val & out_rdy & ~squash;
   end

   // Next-state for occupancy, pointers, storage and the illegal counter.
   always_comb begin
      count_d       = count_q;
      head_d        = head_q;
      tail_d        = tail_q;
      illegal_cnt_d = illegal_cnt_q;
      ent_d         = ent_q;
      if (squash) begin
         count_d = 2'd0;
         head_d  = 1'b0;
         tail_d  = 1'b0;
      end else begin
         if (enq_fire) begin
            ent_d[tail_q] = new_ent;
            tail_d        = ~tail_q;
         end else begin
            tail_d = tail_q;
         end
         if (deq_fire) begin
            head_d = ~head_q;
            if (ent_q[head_q].illegal) begin
               illegal_cnt_d = sat_inc(illegal_cnt_q);
            end else begin
               illegal_cnt_d = illegal_cnt_q;
            end
         end else begin
            head_d = head_q;
         end
         case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q       <= 2'd0;
         head_q        <= 1'b0;
         tail_q        <= 1'b0;
         illegal_cnt_q <= '0;
         for (int i = 0; i < p_depth; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         count_q       <= count_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         illegal_cnt_q <= illegal_cnt_d;
         ent_q         <= ent_d;
      end
   end

   // Head mux; data outputs are forced to zero whenever no entry is valid.
   always_comb begin
      if (out_val) begin
         head_ent = ent_q[head_q];
      end else begin
         head_ent = '0;
      end
      out_inst     = head_ent.inst;
      out_imm_type = head_ent.imm_type;
      out_imm_use  = head_ent.imm_use;
      out_illegal  = head_ent.illegal;
      illegal_cnt  = illegal_cnt_q;
   end

endmodule

// File: tb/tb_lab2_proc_decode_imm_sched.sv
// Directed self-checking bench for lab2_proc_decode_imm_sched.
module tb_lab2_proc_decode_imm_sched;

   logic        clk;
   logic        reset;
   logic        in_val;
   logic        in_rdy;
   logic [31:0] in_inst;
   logic        squash;
   logic        out_val;
   logic        out_rdy;
   logic [31:0] out_inst;
   logic [2:0]  out_imm_type;
   logic        out_imm_use;
   logic        out_illegal;
   logic [7:0]  illegal_cnt;

   int n_checks = 0;
   int n_errors = 0;

   lab2_proc_decode_imm_sched #(.p_depth(2), .p_cnt_nbits(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_val       (in_val),
      .in_rdy       (in_rdy),
      .in_inst      (in_inst),
      .squash       (squash),
      .out_val      (out_val),
      .out_rdy      (out_rdy),
      .out_inst     (out_inst),
      .out_imm_type (out_imm_type),
      .out_imm_use  (out_imm_use),
      .out_illegal  (out_illegal),
      .illegal_cnt  (illegal_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] sweep_inst [5];
   logic [2:0]  sweep_type [5];
   logic        sweep_use  [5];
   int          exp_cnt;

   initial begin
      sweep_inst[0] = 32'h00112023; sweep_type[0] = 3'd1; sweep_use[0] = 1'b1;
      sweep_inst[1] = 32'h00208463; sweep_type[1] = 3'd2; sweep_use[1] = 1'b1;
      sweep_inst[2] = 32'h123450B7; sweep_type[2] = 3'd3; sweep_use[2] = 1'b1;
      sweep_inst[3] = 32'h008000EF; sweep_type[3] = 3'd4; sweep_use[3] = 1'b1;
      sweep_inst[4] = 32'h002081B3; sweep_type[4] = 3'd0; sweep_use[4] = 1'b0;

      reset   = 1'b0;
      in_val  = 1'b0;
      in_inst = 32'h0;
      squash  = 1'b0;
      out_rdy = 1'b0;
      tick();
      tick();
      check("rst_out_val", {31'd0, out_val}, 32'd0);
      check("rst_in_rdy", {31'd0, in_rdy}, 32'd0);
      check("rst_cnt", {24'd0, illegal_cnt}, 32'd0);
      check("rst_out_inst", out_inst, 32'd0);

      // single addi
      reset = 1'b1;
      #1;
      check("rel_in_rdy", {31'd0, in_rdy}, 32'd1);
      check("rel_out_val", {31'd0, out_val}, 32'd0);
      in_val  = 1'b1;
      in_inst = 32'h00500093;
      tick();
      in_val = 1'b0;
      check("addi_val", {31'd0, out_val}, 32'd1);
      check("addi_inst", out_inst, 32'h00500093);
      check("addi_type", {29'd0, out_imm_type}, 32'd0);
      check("addi_use", {31'd0, out_imm_use}, 32'd1);
      check("addi_ill", {31'd0, out_illegal}, 32'd0);
      out_rdy = 1'b1;
      tick();
      out_rdy = 1'b0;
      check("addi_drain_val", {31'd0, out_val}, 32'd0);
      check("addi_drain_type", {29'd0, out_imm_type}, 32'd0);
      check("addi_drain_rdy", {31'd0, in_rdy}, 32'd1);

      // format sweep at full throughput
      out_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_val  = 1'b1;
         in_inst = sweep_inst[i];
         tick();
         check($sformatf("sweep%0d_val", i), {31'd0, out_val}, 32'd1);
         check($sformatf("sweep%0d_inst", i), out_inst, sweep_inst[i]);
         check($sformatf("sweep%0d_type", i), {29'd0, out_imm_type}, {29'd0, sweep_type[i]});
         check($sformatf("sweep%0d_use", i), {31'd0, out_imm_use}, {31'd0, sweep_use[i]});
         check($sformatf("sweep%0d_rdy", i), {31'd0, in_rdy}, 32'd1);
      end
      in_val = 1'b0;
      tick();
      check("sweep_empty", {31'd0, out_val}, 32'd0);

      // fill under backpressure, third is held off
      out_rdy = 1'b0;
      in_val  = 1'b1;
      in_inst = 32'h00000013;
      tick();
      in_inst = 32'h00112023;
      tick();
      check("full_in_rdy", {31'd0, in_rdy}, 32'd0);
      in_inst = 32'h123450B7;
      tick();
      check("full_hold_rdy", {31'd0, in_rdy}, 32'd0);
      check("full_head", out_inst, 32'h00000013);
      out_rdy = 1'b1;
      tick();
      check("full_deq1", out_inst, 32'h00112023);
      check("full_deq1_type", {29'd0, out_imm_type}, 32'd1);
      check("full_deq1_rdy", {31'd0, in_rdy}, 32'd1);
      tick();
      in_val = 1'b0;
      check("wrap_inst", out_inst, 32'h123450B7);
      check("wrap_type", {29'd0, out_imm_type}, 32'd3);
      tick();
      out_rdy = 1'b0;
      check("wrap_empty", {31'd0, out_val}, 32'd0);

      // squash with enqueue and dequeue requested in the same cycle
      in_val  = 1'b1;
      in_inst = 32'hFFFFFFFF;
      tick();
      tick();
      check("sq_full", {31'd0, in_rdy}, 32'd0);
      check("sq_head_ill", {31'd0, out_illegal}, 32'd1);
      squash  = 1'b1;
      out_rdy = 1'b1;
      tick();
      squash  = 1'b0;
      in_val  = 1'b0;
      out_rdy = 1'b0;
      check("sq_out_val", {31'd0, out_val}, 32'd0);
      check("sq_in_rdy", {31'd0, in_rdy}, 32'd1);
      check("sq_cnt", {24'd0, illegal_cnt}, 32'd0);
      check("sq_out_inst", out_inst, 32'd0);
      tick();
      check("sq_stays_empty", {31'd0, out_val}, 32'd0);

      // 300 illegal instructions, counter saturates at 255
      out_rdy = 1'b1;
      in_val  = 1'b1;
      in_inst = 32'hFFFFFFFF;
      for (int k = 1; k <= 300; k++) begin
         tick();
         exp_cnt = (k - 1 > 255) ? 255 : k - 1;
         check($sformatf("ill%0d_flag", k), {31'd0, out_illegal}, 32'd1);
         check($sformatf("ill%0d_cnt", k), {24'd0, illegal_cnt}, exp_cnt);
      end
      in_val = 1'b0;
      tick();
      out_rdy = 1'b0;
      check("ill_sat", {24'd0, illegal_cnt}, 32'd255);
      check("ill_empty", {31'd0, out_val}, 32'd0);

      // reset mid-stream with the buffer full, squash also raised
      in_val  = 1'b1;
      in_inst = 32'h00500093;
      tick();
      tick();
      in_val = 1'b0;
      check("mid_full", {31'd0, in_rdy}, 32'd0);
      reset  = 1'b0;
      squash = 1'b1;
      tick();
      squash = 1'b0;
      check("mid_out_val", {31'd0, out_val}, 32'd0);
      check("mid_in_rdy", {31'd0, in_rdy}, 32'd0);
      check("mid_cnt", {24'd0, illegal_cnt}, 32'd0);
      check("mid_out_inst", out_inst, 32'd0);
      reset = 1'b1;
      #1;
      check("mid_rel_rdy", {31'd0, in_rdy}, 32'd1);
      check("mid_rel_val", {31'd0, out_val}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
